// File: rtl/video_rx_capture.sv
// Video receiver frame capture: registers the incoming video, checks line/frame geometry,
// writes active pixels to a linear frame buffer and measures sync periods.
module video_rx_capture #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned V_ACTIVE = 480
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] In_pData,
    input  logic        In_pVSync,
    input  logic        In_pHSync,
    input  logic        In_pVDE,
    input  logic        Cap_En,
    input  logic        Err_Clear,
    output logic        Mem_Write,
    output logic [18:0] Mem_Addr,
    output logic [23:0] Mem_Data,
    output logic        Frame_Done,
    output logic        Frame_Odd,
    output logic [15:0] Meas_Htotal,
    output logic [31:0] Meas_Vtotal,
    output logic        Err_Hlen,
    output logic        Err_Vlen
);

    localparam int unsigned AW = 19;
    localparam int unsigned DW = 24;
    localparam int unsigned PW = 16;
    localparam int unsigned LW = 16;
    localparam int unsigned HW = 16;
    localparam int unsigned VW = 32;
    localparam logic [AW-1:0] ADDR_MAX = AW'(H_ACTIVE * V_ACTIVE - 1);
    localparam logic [PW-1:0] PIX_LEN  = PW'(H_ACTIVE);
    localparam logic [LW-1:0] LINE_NUM = LW'(V_ACTIVE);

    typedef enum logic [1:0] {IDLE, WAIT_ACT, ACTIVE, SKIP} state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] data_q, data_d;
    logic          vs_q, vs_d, hs_q, hs_d, vde_q, vde_d;
    logic          vs_prev_q, hs_prev_q, vde_prev_q;
    logic [AW-1:0] addr_q, addr_d;
    logic [PW-1:0] pix_q, pix_d;
    logic [LW-1:0] line_q, line_d;
    logic [HW-1:0] hcnt_q, hcnt_d, meas_h_q, meas_h_d;
    logic [VW-1:0] vcnt_q, vcnt_d, meas_v_q, meas_v_d;
    logic          hseen_q, hseen_d, vseen_q, vseen_d;
    logic          err_h_q, err_h_d, err_v_q, err_v_d;
    logic          done_q, done_d, odd_q, odd_d;

    logic frame_start, hs_fall, vde_rise, vde_fall;
    logic capturing, line_check, line_bad, line_last;

    // Edge detection works only on the registered copies of the video inputs.
    assign frame_start = vs_prev_q & ~vs_q;
    assign hs_fall     = hs_prev_q & ~hs_q;
    assign vde_rise    = ~vde_prev_q & vde_q;
    assign vde_fall    = vde_prev_q & ~vde_q;
    assign capturing   = (state_q == WAIT_ACT) || (state_q == ACTIVE);
    assign line_check  = (state_q == ACTIVE) && vde_fall && !frame_start;
    assign line_bad    = pix_q != PIX_LEN;
    assign line_last   = (line_q + LW'(1)) == LINE_NUM;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Frame start overrides every other transition and re-samples Cap_En.
    always_comb begin
        state_d = state_q;
        if (frame_start) begin
            state_d = Cap_En ? WAIT_ACT : IDLE;
        end else begin
            unique case (state_q)
                WAIT_ACT: if (vde_rise) state_d = ACTIVE;
                ACTIVE: begin
                    if (line_check && line_bad)       state_d = SKIP;
                    else if (line_check && line_last) state_d = IDLE;
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        data_d   = In_pData;
        vs_d     = In_pVSync;
        hs_d     = In_pHSync;
        vde_d    = In_pVDE;
        addr_d   = addr_q;
        pix_d    = pix_q;
        line_d   = line_q;
        hcnt_d   = (hcnt_q == '1) ? hcnt_q : hcnt_q + HW'(1);
        vcnt_d   = (vcnt_q == '1) ? vcnt_q : vcnt_q + VW'(1);
        meas_h_d = meas_h_q;
        meas_v_d = meas_v_q;
        hseen_d  = hseen_q | hs_fall;
        vseen_d  = vseen_q | frame_start;
        err_h_d  = (err_h_q & ~Err_Clear) | (line_check & line_bad);
        err_v_d  = (err_v_q & ~Err_Clear) | (frame_start & capturing & (line_q != LINE_NUM));
        done_d   = line_check & ~line_bad & line_last;
        odd_d    = odd_q ^ frame_start;

        Mem_Write = capturing & vde_q;
        Mem_Data  = Mem_Write ? data_q : '0;

        if (frame_start) begin
            addr_d = '0;
            pix_d  = '0;
            line_d = '0;
        end else begin
            if (Mem_Write && addr_q != ADDR_MAX) addr_d = addr_q + AW'(1);
            if (vde_fall)                        pix_d  = '0;
            else if (vde_q && pix_q != '1)       pix_d  = pix_q + PW'(1);
            if (line_check && !line_bad)         line_d = line_q + LW'(1);
        end

        // The first edge after reset only restarts the period counters.
        if (hs_fall) begin
            hcnt_d = HW'(1);
            if (hseen_q) meas_h_d = hcnt_q;
        end
        if (frame_start) begin
            vcnt_d = VW'(1);
            if (vseen_q) meas_v_d = vcnt_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q     <= '0;
            vs_q       <= 1'b1;
            hs_q       <= 1'b1;
            vde_q      <= 1'b0;
            vs_prev_q  <= 1'b1;
            hs_prev_q  <= 1'b1;
            vde_prev_q <= 1'b0;
            addr_q     <= '0;
            pix_q      <= '0;
            line_q     <= '0;
            hcnt_q     <= '0;
            vcnt_q     <= '0;
            meas_h_q   <= '0;
            meas_v_q   <= '0;
            hseen_q    <= 1'b0;
            vseen_q    <= 1'b0;
            err_h_q    <= 1'b0;
            err_v_q    <= 1'b0;
            done_q     <= 1'b0;
            odd_q      <= 1'b0;
        end else begin
            data_q     <= data_d;
            vs_q       <= vs_d;
            hs_q       <= hs_d;
            vde_q      <= vde_d;
            vs_prev_q  <= vs_q;
            hs_prev_q  <= hs_q;
            vde_prev_q <= vde_q;
            addr_q     <= addr_d;
            pix_q      <= pix_d;
            line_q     <= line_d;
            hcnt_q     <= hcnt_d;
            vcnt_q     <= vcnt_d;
            meas_h_q   <= meas_h_d;
            meas_v_q   <= meas_v_d;
            hseen_q    <= hseen_d;
            vseen_q    <= vseen_d;
            err_h_q    <= err_h_d;
            err_v_q    <= err_v_d;
            done_q     <= done_d;
            odd_q      <= odd_d;
        end
    end

    assign Mem_Addr    = addr_q;
    assign Frame_Done  = done_q;
    assign Frame_Odd   = odd_q;
    assign Meas_Htotal = meas_h_q;
    assign Meas_Vtotal = meas_v_q;
    assign Err_Hlen    = err_h_q;
    assign Err_Vlen    = err_v_q;

endmodule
